// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encoding and op classification helpers for the
// iterative multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

  // MULT/MULTU/DIV/DIVU occupy the lower half of the op space.
  function automatic logic is_iter_op(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return ~op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Work registers for the radix-2 engine: shift-add multiply and restoring
// shift-subtract divide, both advanced one bit per enabled step.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a_mag,
  input  logic [WIDTH-1:0]     b_mag,
  output logic [2*WIDTH-1:0]   prod,
  output logic [WIDTH-1:0]     quot,
  output logic [WIDTH-1:0]     rem
);

  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The multiplier sits in the low half of prod and is consumed LSB first;
  // the dividend sits in quot and is consumed MSB first while quotient bits
  // shift in behind it.
  always_comb begin
    add_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd_b} : '0);
    shifted = {rem, quot[WIDTH-1]};
    fits    = shifted >= {1'b0, opnd_b};
    diff    = shifted[WIDTH-1:0] - opnd_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_b <= '0;
      prod   <= '0;
      quot   <= '0;
      rem    <= '0;
    end else if (load) begin
      opnd_b <= b_mag;
      prod   <= {{WIDTH{1'b0}}, a_mag};
      quot   <= a_mag;
      rem    <= '0;
    end else if (step) begin
      prod <= {add_sum, prod[WIDTH-1:1]};
      if (fits) begin
        rem  <= diff;
        quot <= {quot[WIDTH-2:0], 1'b1};
      end else begin
        rem  <= shifted[WIDTH-1:0];
        quot <= {quot[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and
// the busy/stall handshake used by the hazard unit.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             rd_req,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               sign_a, sign_b, kind_div, b_zero;
  logic [WIDTH-1:0]   a_raw;
  logic               accept, iter_go, signed_op, last_step, commit, step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod, mul_res;
  logic [WIDTH-1:0]   quot, rem, div_hi, div_lo;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign busy      = (state != S_IDLE);
  assign ready     = ~busy;
  assign stall     = rd_req & busy;
  assign accept    = start & ~flush & (state == S_IDLE);
  assign iter_go   = accept & is_iter_op(op);
  assign signed_op = is_signed_op(op);
  assign a_mag     = cond_neg(a, signed_op & a[WIDTH-1]);
  assign b_mag     = cond_neg(b, signed_op & b[WIDTH-1]);
  assign last_step = (cnt == CW'(WIDTH - 1));
  assign commit    = (state == S_FIXUP) & ~flush;
  assign step      = (state == S_RUN) & ~flush;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (iter_go),
    .step  (step),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .prod  (prod),
    .quot  (quot),
    .rem   (rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (iter_go) state_nxt = S_RUN;
      S_RUN:   if (flush) state_nxt = S_IDLE;
               else if (last_step) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      kind_div <= 1'b0;
      b_zero   <= 1'b0;
      a_raw    <= '0;
      done     <= 1'b0;
    end else begin
      done <= commit;
      if (iter_go) begin
        cnt      <= '0;
        sign_a   <= signed_op & a[WIDTH-1];
        sign_b   <= signed_op & b[WIDTH-1];
        kind_div <= op[1];
        b_zero   <= (b == '0);
        a_raw    <= a;
      end else if (state == S_RUN) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Sign fixup: quotient sign is the XOR of operand signs, remainder follows
  // the dividend; a zero divisor returns the dividend untouched in HI.
  always_comb begin
    mul_res = cond_neg_wide(prod, sign_a ^ sign_b);
    div_lo  = cond_neg(quot, sign_a ^ sign_b);
    div_hi  = cond_neg(rem, sign_a);
    if (b_zero) begin
      div_lo = '1;
      div_hi = a_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= kind_div ? div_hi : mul_res[2*WIDTH-1:WIDTH];
      lo <= kind_div ? div_lo : mul_res[WIDTH-1:0];
    end else if (accept && op == MDU_MTHI) begin
      hi <= a;
    end else if (accept && op == MDU_MTLO) begin
      lo <= a;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomized and directed bench for mdu_hilo against an arithmetic reference.
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         rd_req = 1'b0;
  logic         ready, busy, done, stall;
  logic [W-1:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  mdu_hilo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .rd_req(rd_req), .ready(ready), .busy(busy),
    .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_md(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] h, output logic [W-1:0] l);
    longint     sx, sy, q, r;
    logic [63:0] p, q64, r64;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    h = '0;
    l = '0;
    case (o)
      MDU_MULT:  begin p = 64'(sx * sy); h = p[63:32]; l = p[31:0]; end
      MDU_MULTU: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
      MDU_DIV, MDU_DIVU: begin
        if (y == 0) begin
          h = x;
          l = '1;
        end else begin
          if (o == MDU_DIV) begin
            q = sx / sy;
            r = sx % sy;
          end else begin
            q = longint'({32'b0, x}) / longint'({32'b0, y});
            r = longint'({32'b0, x}) % longint'({32'b0, y});
          end
          q64 = q;
          r64 = r;
          h = r64[31:0];
          l = q64[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  // Issues one iterative op and follows it to completion.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic second_start);
    int cyc, busy_bad, stall_bad;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_bad = 0; stall_bad = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) busy_bad++;
      if (stall !== rd_req) stall_bad++;
      if (second_start && cyc == 5) begin
        op = MDU_MTHI; a = 32'hDEAD_BEEF; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    exp_hi = eh;
    exp_lo = el;
    chk({tag, "_latency"}, 64'(cyc), 64'd34);
    chk({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    chk({tag, "_stall_run"}, 64'(stall_bad), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_idle"}, {62'd0, busy, ready}, 64'd1);
    chk({tag, "_stall_done"}, 64'(stall), 64'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  typedef struct {
    logic [2:0]   o;
    logic [W-1:0] x, y, eh, el;
  } vec_t;

  vec_t vecs[9] = '{
    '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
    '{MDU_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1},
    '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
    '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003},
    '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
    '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    '{MDU_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF},
    '{MDU_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF}
  };

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rx, ry, rh, rl;
    int           done_seen;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);

    foreach (vecs[i]) run_op($sformatf("dir%0d", i), vecs[i].o, vecs[i].x, vecs[i].y,
                             vecs[i].eh, vecs[i].el, 1'b0);

    // MTHI / MTLO are single-cycle and never raise busy or done.
    @(negedge clk); op = MDU_MTHI; a = 32'h1234; start = 1'b1;
    @(negedge clk); start = 1'b0;
    exp_hi = 32'h1234;
    chk("mthi_hi", 64'(hi), 64'(exp_hi));
    chk("mthi_lo", 64'(lo), 64'(exp_lo));
    chk("mthi_busy_done", {62'd0, busy, done}, 64'd0);
    op = MDU_MTLO; a = 32'h5678; start = 1'b1;
    @(negedge clk); start = 1'b0;
    exp_lo = 32'h5678;
    chk("mtlo_lo", 64'(lo), 64'(exp_lo));
    chk("mtlo_hi", 64'(hi), 64'(exp_hi));

    op = 3'b110; a = 32'hFFFF0000; b = 32'h1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("noop_hilo", {hi, lo}, {exp_hi, exp_lo});
    chk("noop_busy", 64'(busy), 64'd0);

    op = MDU_MTHI; a = 32'hAAAA5555; start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    chk("flush_idle_hi", 64'(hi), 64'(exp_hi));

    // Stall tracking plus an ignored start while busy.
    rd_req = 1'b1;
    ref_md(MDU_MULT, 32'h0001E240, 32'hFFFF5A5A, rh, rl);
    run_op("stall", MDU_MULT, 32'h0001E240, 32'hFFFF5A5A, rh, rl, 1'b1);
    rd_req = 1'b0;

    // Flush at cnt==10: op vanishes, HI/LO keep their prior values.
    @(negedge clk); op = MDU_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("flush_no_done", 64'(done_seen), 64'd0);
    chk("flush_hilo", {hi, lo}, {exp_hi, exp_lo});

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = '0;
        1: ry = W'($urandom_range(1, 15));
        2: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
        default: ;
      endcase
      ref_md(ro, rx, ry, rh, rl);
      run_op($sformatf("rnd%0d", i), ro, rx, ry, rh, rl, 1'b0);
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk); op = MDU_MULTU; a = 32'h12345678; b = 32'h9ABCDEF0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("arst_after_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
